// File: rtl/stage_memory_hs_if.sv
// ----------------------------------------------------------------------------
// stage_memory_hs_pkg / stage_memory_hs_if
//
// Purpose:
//    Shared types for the memory-access stage and the data-memory bus
//    interface it drives.
//
// Interface signals (data-memory req/ack bus):
//    req         master->slave  request outstanding
//    we          master->slave  1 = store
//    addr        master->slave  word-aligned byte address
//    write_data  master->slave  store data already shifted onto byte lanes
//    write_mask  master->slave  byte enables
//    ack         slave->master  request complete, read_data valid this cycle
//    err         slave->master  qualifies ack: bus error
//    read_data   slave->master  read word
// ----------------------------------------------------------------------------
package stage_memory_hs_pkg;

   typedef enum logic [1:0] {
      MA_X     = 2'd0,
      MA_LOAD  = 2'd1,
      MA_STORE = 2'd2
   } ma_mode_t;

   typedef enum logic [1:0] {
      MA_B = 2'd0,
      MA_H = 2'd1,
      MA_W = 2'd2
   } ma_size_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_CSR = 2'd3
   } wb_src_t;

   localparam logic [3:0] CAUSE_NONE             = 4'd0;
   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
   localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

endpackage

interface stage_memory_hs_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [3:0]  write_mask;
   logic        ack;
   logic        err;
   logic [31:0] read_data;

   modport master (
      output req, we, addr, write_data, write_mask,
      input  ack, err, read_data
   );

   modport slave (
      input  req, we, addr, write_data, write_mask,
      output ack, err, read_data
   );
endinterface

// File: rtl/stage_memory_hs.sv
// ----------------------------------------------------------------------------
// stage_memory_hs
//
// Purpose:
//    RV32 memory-access pipeline stage between execute and write-back.
//    Non-memory instructions pass through in one cycle. Loads and stores
//    issue a registered request on a variable-latency req/ack data bus and
//    stall upstream (ready_o low) until the bus acknowledges or times out.
//    Load data is lane-selected and sign/zero-extended here. Misaligned
//    accesses and bus errors/timeouts retire as traps.
//
// Ports:
//    clk_i, reset_i     clock, synchronous active-high reset
//    valid_i / ready_o  upstream handshake (accept = valid_i && ready_o)
//    pc_i, ir_i         instruction being retired
//    ma_*_i             access mode, size, address and unshifted store data
//    wb_*_i             write-back source, non-memory result, rd-write flag
//    dmem               data-memory bus (master side)
//    valid_o            one-cycle pulse per retiring instruction
//    pc_o, ir_o, wb_*_o registered retire information
//    trap_o, trap_cause_o  trap flag and cause (4/5/6/7)
//    empty_async_o      combinational: idle and nothing useful arriving
// ----------------------------------------------------------------------------
module stage_memory_hs
   import stage_memory_hs_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES  = 16,
   parameter bit          TRAP_MISALIGNED = 1'b1,
   parameter logic [31:0] NOP_PC          = 32'h0000_0000,
   parameter logic [31:0] NOP_IR          = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        reset_i,

   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] pc_i,
   input  logic [31:0] ir_i,
   input  logic [31:0] ma_addr_i,
   input  ma_mode_t    ma_mode_i,
   input  ma_size_t    ma_size_i,
   input  logic [31:0] ma_data_i,
   input  wb_src_t     wb_src_i,
   input  logic [31:0] wb_data_i,
   input  logic        wb_valid_i,

   stage_memory_hs_if.master dmem,

   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] ir_o,
   output logic [4:0]  wb_addr_o,
   output logic [31:0] wb_data_o,
   output logic        wb_valid_o,
   output logic        trap_o,
   output logic [3:0]  trap_cause_o,
   output logic        empty_async_o
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // Byte enables for a store of the given size at the given byte offset.
   function automatic logic [3:0] store_mask(input ma_size_t size, input logic [1:0] lo);
      logic [3:0] m;
      case (size)
         MA_B:    m = 4'b0001 << lo;
         MA_H:    m = lo[1] ? 4'b1100 : 4'b0011;
         MA_W:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic is_misaligned(input ma_size_t size, input logic [1:0] lo);
      logic mis;
      case (size)
         MA_H:    mis = lo[0];
         MA_W:    mis = (lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Lane offset used for read data; a misaligned access that was allowed
   // onto the bus reads from the naturally aligned lane.
   function automatic logic [1:0] load_lane(input ma_size_t size, input logic [1:0] lo);
      logic [1:0] l;
      case (size)
         MA_B:    l = lo;
         MA_H:    l = {lo[1], 1'b0};
         default: l = 2'b00;
      endcase
      return l;
   endfunction

   // Select the addressed lane and extend to 32 bits (uns = LBU/LHU).
   function automatic logic [31:0] load_align(input logic [31:0] rdata, input ma_size_t size,
                                              input logic [1:0] lane, input logic uns);
      logic [31:0] sh;
      logic [31:0] r;
      sh = rdata >> {lane, 3'b000};
      case (size)
         MA_B:    r = uns ? {24'h00_0000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         MA_H:    r = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         MA_W:    r = sh;
         default: r = sh;
      endcase
      return r;
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    mask_q, mask_d;

   // Instruction fields held while the bus access is outstanding.
   logic [31:0]   lat_pc_q, lat_pc_d;
   logic [31:0]   lat_ir_q, lat_ir_d;
   ma_size_t      lat_size_q, lat_size_d;
   logic [1:0]    lat_lane_q, lat_lane_d;
   wb_src_t       lat_src_q, lat_src_d;
   logic [31:0]   lat_wbd_q, lat_wbd_d;
   logic          lat_wbv_q, lat_wbv_d;

   logic          valid_q, valid_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   ir_q, ir_d;
   logic [4:0]    wb_addr_q, wb_addr_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic          wb_valid_q, wb_valid_d;
   logic          trap_q, trap_d;
   logic [3:0]    cause_q, cause_d;

   logic          mis_s;
   logic [31:0]   load_val_s;

   assign mis_s      = is_misaligned(ma_size_i, ma_addr_i[1:0]);
   assign load_val_s = load_align(dmem.read_data, lat_size_q, lat_lane_q, lat_ir_q[14]);

   // Next-state, bus payload and retire-register logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      lat_pc_d   = lat_pc_q;
      lat_ir_d   = lat_ir_q;
      lat_size_d = lat_size_q;
      lat_lane_d = lat_lane_q;
      lat_src_d  = lat_src_q;
      lat_wbd_d  = lat_wbd_q;
      lat_wbv_d  = lat_wbv_q;
      valid_d    = 1'b0;
      pc_d       = pc_q;
      ir_d       = ir_q;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      wb_valid_d = wb_valid_q;
      trap_d     = trap_q;
      cause_d    = cause_q;

      case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               case (ma_mode_i)
                  MA_LOAD, MA_STORE: begin
                     if (mis_s && TRAP_MISALIGNED) begin
                        valid_d    = 1'b1;
                        pc_d       = pc_i;
                        ir_d       = ir_i;
                        wb_addr_d  = ir_i[11:7];
                        wb_data_d  = 32'h0000_0000;
                        wb_valid_d = 1'b0;
                        trap_d     = 1'b1;
                        cause_d    = (ma_mode_i == MA_STORE) ? CAUSE_STORE_MISALIGNED
                                                             : CAUSE_LOAD_MISALIGNED;
                     end else begin
                        state_d    = S_BUSY;
                        cnt_d      = '0;
                        req_d      = 1'b1;
                        we_d       = (ma_mode_i == MA_STORE);
                        addr_d     = {ma_addr_i[31:2], 2'b00};
                        wdata_d    = ma_data_i << {ma_addr_i[1:0], 3'b000};
                        // Loads and tolerated misaligned accesses write no bytes.
                        mask_d     = ((ma_mode_i == MA_STORE) && !mis_s)
                                     ? store_mask(ma_size_i, ma_addr_i[1:0]) : 4'b0000;
                        lat_pc_d   = pc_i;
                        lat_ir_d   = ir_i;
                        lat_size_d = ma_size_i;
                        lat_lane_d = load_lane(ma_size_i, ma_addr_i[1:0]);
                        lat_src_d  = wb_src_i;
                        lat_wbd_d  = wb_data_i;
                        lat_wbv_d  = wb_valid_i;
                     end
                  end
                  default: begin
                     valid_d    = 1'b1;
                     pc_d       = pc_i;
                     ir_d       = ir_i;
                     wb_addr_d  = ir_i[11:7];
                     wb_data_d  = wb_data_i;
                     wb_valid_d = wb_valid_i;
                     trap_d     = 1'b0;
                     cause_d    = CAUSE_NONE;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end

         S_BUSY: begin
            // An ack on the final timeout cycle wins over the timeout.
            if (dmem.ack) begin
               state_d   = S_IDLE;
               req_d     = 1'b0;
               valid_d   = 1'b1;
               pc_d      = lat_pc_q;
               ir_d      = lat_ir_q;
               wb_addr_d = lat_ir_q[11:7];
               if (dmem.err) begin
                  wb_data_d  = 32'h0000_0000;
                  wb_valid_d = 1'b0;
                  trap_d     = 1'b1;
                  cause_d    = we_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
               end else if (we_q) begin
                  wb_data_d  = lat_wbd_q;
                  wb_valid_d = 1'b0;
                  trap_d     = 1'b0;
                  cause_d    = CAUSE_NONE;
               end else begin
                  // rd receives the loaded value when write-back is routed from memory.
                  wb_data_d  = (lat_src_q == WB_MEM) ? load_val_s : lat_wbd_q;
                  wb_valid_d = lat_wbv_q;
                  trap_d     = 1'b0;
                  cause_d    = CAUSE_NONE;
               end
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
               state_d    = S_IDLE;
               req_d      = 1'b0;
               valid_d    = 1'b1;
               pc_d       = lat_pc_q;
               ir_d       = lat_ir_q;
               wb_addr_d  = lat_ir_q[11:7];
               wb_data_d  = 32'h0000_0000;
               wb_valid_d = 1'b0;
               trap_d     = 1'b1;
               cause_d    = we_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State, bus payload and retire registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0000_0000;
         wdata_q    <= 32'h0000_0000;
         mask_q     <= 4'b0000;
         lat_pc_q   <= 32'h0000_0000;
         lat_ir_q   <= 32'h0000_0000;
         lat_size_q <= MA_B;
         lat_lane_q <= 2'b00;
         lat_src_q  <= WB_ALU;
         lat_wbd_q  <= 32'h0000_0000;
         lat_wbv_q  <= 1'b0;
         valid_q    <= 1'b0;
         pc_q       <= NOP_PC;
         ir_q       <= NOP_IR;
         wb_addr_q  <= 5'd0;
         wb_data_q  <= 32'h0000_0000;
         wb_valid_q <= 1'b0;
         trap_q     <= 1'b0;
         cause_q    <= CAUSE_NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
         lat_pc_q   <= lat_pc_d;
         lat_ir_q   <= lat_ir_d;
         lat_size_q <= lat_size_d;
         lat_lane_q <= lat_lane_d;
         lat_src_q  <= lat_src_d;
         lat_wbd_q  <= lat_wbd_d;
         lat_wbv_q  <= lat_wbv_d;
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         wb_valid_q <= wb_valid_d;
         trap_q     <= trap_d;
         cause_q    <= cause_d;
      end
   end

   assign ready_o       = (state_q == S_IDLE);
   assign empty_async_o = (state_q == S_IDLE) && (!valid_i || (pc_i == NOP_PC));

   assign dmem.req        = req_q;
   assign dmem.we         = we_q;
   assign dmem.addr       = addr_q;
   assign dmem.write_data = wdata_q;
   assign dmem.write_mask = mask_q;

   assign valid_o      = valid_q;
   assign pc_o         = pc_q;
   assign ir_o         = ir_q;
   assign wb_addr_o    = wb_addr_q;
   assign wb_data_o    = wb_data_q;
   assign wb_valid_o   = wb_valid_q;
   assign trap_o       = trap_q;
   assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_stage_memory_hs.sv
// ----------------------------------------------------------------------------
// tb_stage_memory_hs
//
// Directed bench for stage_memory_hs with default parameters
// (TIMEOUT_CYCLES=16, TRAP_MISALIGNED=1, NOP_PC=0, NOP_IR=0x13).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_stage_memory_hs;
   import stage_memory_hs_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] pc_i, ir_i, ma_addr_i, ma_data_i, wb_data_i;
   ma_mode_t    ma_mode_i;
   ma_size_t    ma_size_i;
   wb_src_t     wb_src_i;
   logic        wb_valid_i;
   logic        valid_o;
   logic [31:0] pc_o, ir_o, wb_data_o;
   logic [4:0]  wb_addr_o;
   logic        wb_valid_o, trap_o, empty_async_o;
   logic [3:0]  trap_cause_o;

   stage_memory_hs_if dmem_bus ();

   int vectors = 0;
   int miscompares = 0;
   int req_cnt = 0;
   int rdy_low_cnt = 0;
   int base_req, base_rdy, n;

   stage_memory_hs dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .pc_i          (pc_i),
      .ir_i          (ir_i),
      .ma_addr_i     (ma_addr_i),
      .ma_mode_i     (ma_mode_i),
      .ma_size_i     (ma_size_i),
      .ma_data_i     (ma_data_i),
      .wb_src_i      (wb_src_i),
      .wb_data_i     (wb_data_i),
      .wb_valid_i    (wb_valid_i),
      .dmem          (dmem_bus),
      .valid_o       (valid_o),
      .pc_o          (pc_o),
      .ir_o          (ir_o),
      .wb_addr_o     (wb_addr_o),
      .wb_data_o     (wb_data_o),
      .wb_valid_o    (wb_valid_o),
      .trap_o        (trap_o),
      .trap_cause_o  (trap_cause_o),
      .empty_async_o (empty_async_o)
   );

   always #5 clk_i = ~clk_i;

   // Cycle counters for request-high and stall durations.
   always @(negedge clk_i) begin
      if (dmem_bus.req) req_cnt = req_cnt + 1;
      if (!ready_o) rdy_low_cnt = rdy_low_cnt + 1;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one instruction with valid_i high and clock the accept edge.
   task automatic issue(input ma_mode_t mode, input ma_size_t size, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] wbd, input logic wbv, input wb_src_t src);
      ma_mode_i  = mode;
      ma_size_i  = size;
      ma_addr_i  = addr;
      ma_data_i  = data;
      ir_i       = ir;
      pc_i       = pc;
      wb_data_i  = wbd;
      wb_valid_i = wbv;
      wb_src_i   = src;
      valid_i    = 1'b1;
      step();
      valid_i    = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1;
      valid_i = 1'b0;
      pc_i = 32'h0; ir_i = 32'h0; ma_addr_i = 32'h0; ma_data_i = 32'h0; wb_data_i = 32'h0;
      ma_mode_i = MA_X; ma_size_i = MA_W; wb_src_i = WB_ALU; wb_valid_i = 1'b0;
      dmem_bus.ack = 1'b0; dmem_bus.err = 1'b0; dmem_bus.read_data = 32'h0;
      step();
      step();
      reset_i = 1'b0;

      // Reset state
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_pc", pc_o, 32'h0000_0000);
      chk("rst_ir", ir_o, 32'h0000_0013);
      chk("rst_wbaddr", wb_addr_o, 5'd0);
      chk("rst_wbdata", wb_data_o, 32'h0);
      chk("rst_wbvalid", wb_valid_o, 1'b0);
      chk("rst_trap", {trap_o, trap_cause_o}, 5'h00);
      chk("rst_req", dmem_bus.req, 1'b0);
      chk("rst_mask", dmem_bus.write_mask, 4'b0000);
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_empty", empty_async_o, 1'b1);

      // empty_async_o follows valid_i / pc_i combinationally
      valid_i = 1'b1; pc_i = 32'h0000_0100; #1;
      chk("empty_busy_pc", empty_async_o, 1'b0);
      pc_i = 32'h0000_0000; #1;
      chk("empty_nop_pc", empty_async_o, 1'b1);
      valid_i = 1'b0;

      // MA_X pass-through, rd = 5
      base_req = req_cnt;
      issue(MA_X, MA_W, 32'h0, 32'h0, 32'h0000_0293, 32'h0000_0100, 32'h0000_1234, 1'b1, WB_ALU);
      chk("x_valid", valid_o, 1'b1);
      chk("x_wbdata", wb_data_o, 32'h0000_1234);
      chk("x_wbaddr", wb_addr_o, 5'd5);
      chk("x_trap", trap_o, 1'b0);
      chk("x_wbvalid", wb_valid_o, 1'b1);
      chk("x_pc", pc_o, 32'h0000_0100);
      step();
      chk("x_pulse", valid_o, 1'b0);
      chk("x_noreq", req_cnt - base_req, 0);

      // LB at 0x1003, ack 3 cycles after req rises
      base_rdy = rdy_low_cnt;
      issue(MA_LOAD, MA_B, 32'h0000_1003, 32'h0, 32'h0000_0303, 32'h0000_0200, 32'h0, 1'b1, WB_MEM);
      chk("lb_req", dmem_bus.req, 1'b1);
      chk("lb_addr", dmem_bus.addr, 32'h0000_1000);
      chk("lb_mask", dmem_bus.write_mask, 4'b0000);
      chk("lb_we", dmem_bus.we, 1'b0);
      chk("lb_ready", ready_o, 1'b0);
      step(); step(); step();
      dmem_bus.ack = 1'b1; dmem_bus.read_data = 32'h80FF_FFFF;
      step();
      dmem_bus.ack = 1'b0;
      chk("lb_valid", valid_o, 1'b1);
      chk("lb_data", wb_data_o, 32'hFFFF_FF80);
      chk("lb_wbaddr", wb_addr_o, 5'd6);
      chk("lb_stall", rdy_low_cnt - base_rdy, 4);
      chk("lb_req_drop", dmem_bus.req, 1'b0);

      // LBU at 0x1003, ack in the first BUSY cycle
      issue(MA_LOAD, MA_B, 32'h0000_1003, 32'h0, 32'h0000_4303, 32'h0000_0204, 32'h0, 1'b1, WB_MEM);
      chk("lbu_notyet", valid_o, 1'b0);
      dmem_bus.ack = 1'b1;
      step();
      dmem_bus.ack = 1'b0;
      chk("lbu_valid", valid_o, 1'b1);
      chk("lbu_data", wb_data_o, 32'h0000_0080);

      // LH at 0x1002, signed upper half
      issue(MA_LOAD, MA_H, 32'h0000_1002, 32'h0, 32'h0000_1383, 32'h0000_0208, 32'h0, 1'b1, WB_MEM);
      dmem_bus.ack = 1'b1; dmem_bus.read_data = 32'h9ABC_0001;
      step();
      dmem_bus.ack = 1'b0;
      chk("lh_data", wb_data_o, 32'hFFFF_9ABC);

      // SH at 0x2002
      issue(MA_STORE, MA_H, 32'h0000_2002, 32'hABCD_1234, 32'h0000_1023, 32'h0000_0300, 32'h0, 1'b1, WB_ALU);
      chk("sh_wdata", dmem_bus.write_data, 32'h1234_0000);
      chk("sh_mask", dmem_bus.write_mask, 4'b1100);
      chk("sh_we", dmem_bus.we, 1'b1);
      chk("sh_addr", dmem_bus.addr, 32'h0000_2000);
      step();
      chk("sh_hold", dmem_bus.write_mask, 4'b1100);
      dmem_bus.ack = 1'b1;
      step();
      dmem_bus.ack = 1'b0;
      chk("sh_valid", valid_o, 1'b1);
      chk("sh_wbvalid", wb_valid_o, 1'b0);
      chk("sh_trap", trap_o, 1'b0);

      // SB at 0x2001
      issue(MA_STORE, MA_B, 32'h0000_2001, 32'h0000_00A5, 32'h0000_0023, 32'h0000_0304, 32'h0, 1'b0, WB_ALU);
      chk("sb_mask", dmem_bus.write_mask, 4'b0010);
      chk("sb_wdata", dmem_bus.write_data, 32'h0000_A500);
      dmem_bus.ack = 1'b1;
      step();
      dmem_bus.ack = 1'b0;

      // LW at 0x3001 misaligned
      base_req = req_cnt;
      issue(MA_LOAD, MA_W, 32'h0000_3001, 32'h0, 32'h0000_2303, 32'h0000_0400, 32'h0, 1'b1, WB_MEM);
      chk("lwm_valid", valid_o, 1'b1);
      chk("lwm_trap", {trap_o, trap_cause_o}, {1'b1, 4'd4});
      chk("lwm_wbvalid", wb_valid_o, 1'b0);
      chk("lwm_ready", ready_o, 1'b1);

      // SH at 0x3003 misaligned
      issue(MA_STORE, MA_H, 32'h0000_3003, 32'h0, 32'h0000_1023, 32'h0000_0404, 32'h0, 1'b0, WB_ALU);
      chk("shm_trap", {trap_o, trap_cause_o}, {1'b1, 4'd6});
      chk("mis_noreq", req_cnt - base_req, 0);

      // LW bus error
      issue(MA_LOAD, MA_W, 32'h0000_3000, 32'h0, 32'h0000_2303, 32'h0000_0408, 32'h0, 1'b1, WB_MEM);
      dmem_bus.ack = 1'b1; dmem_bus.err = 1'b1;
      step();
      dmem_bus.ack = 1'b0; dmem_bus.err = 1'b0;
      chk("lwe_trap", {trap_o, trap_cause_o}, {1'b1, 4'd5});
      chk("lwe_wbvalid", wb_valid_o, 1'b0);

      // SW with no ack: timeout after 16 request cycles
      base_req = req_cnt;
      issue(MA_STORE, MA_W, 32'h0000_5000, 32'h1111_2222, 32'h0000_2023, 32'h0000_0500, 32'h0, 1'b0, WB_ALU);
      n = 0;
      while (!valid_o && n < 40) begin
         step();
         n++;
      end
      chk("to_cycles", n, 16);
      chk("to_reqcnt", req_cnt - base_req, 16);
      chk("to_trap", {trap_o, trap_cause_o}, {1'b1, 4'd7});
      chk("to_req_drop", dmem_bus.req, 1'b0);
      dmem_bus.ack = 1'b1;
      step();
      dmem_bus.ack = 1'b0;
      chk("stray_ack", valid_o, 1'b0);
      issue(MA_X, MA_W, 32'h0, 32'h0, 32'h0000_0393, 32'h0000_0504, 32'h0000_5678, 1'b1, WB_ALU);
      chk("after_to_valid", valid_o, 1'b1);
      chk("after_to_data", wb_data_o, 32'h0000_5678);
      chk("after_to_trap", trap_o, 1'b0);

      // Reset during BUSY
      issue(MA_LOAD, MA_W, 32'h0000_6000, 32'h0, 32'h0000_2303, 32'h0000_0600, 32'h0, 1'b1, WB_MEM);
      chk("rb_req", dmem_bus.req, 1'b1);
      chk("rb_empty", empty_async_o, 1'b0);
      step();
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      chk("rb_req_drop", dmem_bus.req, 1'b0);
      chk("rb_valid", valid_o, 1'b0);
      chk("rb_ready", ready_o, 1'b1);
      dmem_bus.ack = 1'b1;
      step();
      dmem_bus.ack = 1'b0;
      chk("rb_late_ack", valid_o, 1'b0);
      step();
      chk("rb_late_ack2", valid_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
